// File: rtl/npc_exu_pkg.sv
// Shared decode constants, FSM state encoding and multiply/divide op select
// for the iterative execute unit.
package npc_exu_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoding matches funct3 of the RV-M instructions.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/npc_exu_mdu.sv
// Iterative multiply/divide engine. start_i loads magnitudes, then exactly
// XLEN iteration cycles follow; done_o is high during the last one and res_o
// then carries the sign-corrected final value (computed from the last step).
module npc_exu_mdu
  import npc_exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  mdu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            active_q;
  logic [CW-1:0]   cnt_q;
  mdu_op_e         op_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q, dvd_q;
  logic            neg_q, neg_r_q, div0_q;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic [XLEN-1:0] hi_d, lo_d;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  // Operand signedness and magnitudes at start time.
  always_comb begin
    a_signed = (op_i == MDU_MULH) || (op_i == MDU_MULHSU) || (op_i == MDU_DIV) || (op_i == MDU_REM);
    b_signed = (op_i == MDU_MULH) || (op_i == MDU_DIV) || (op_i == MDU_REM);
    a_neg    = a_signed & a_i[XLEN-1];
    b_neg    = b_signed & b_i[XLEN-1];
    a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  // hi holds partial product / remainder, lo holds multiplier / quotient.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    hi_d      = mul_sum[XLEN:1];
    lo_d      = {mul_sum[0], lo_q[XLEN-1:1]};
    if (is_div_op(op_q)) begin
      if (!div_diff[XLEN+1]) begin
        hi_d = div_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = div_shift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fixup and RV-M divide-by-zero override on the final step values.
  always_comb begin
    prod = neg_q ? (~{hi_d, lo_d} + 1'b1) : {hi_d, lo_d};
    quo  = neg_q ? (~lo_d + 1'b1) : lo_d;
    rem  = neg_r_q ? (~hi_d + 1'b1) : hi_d;
    if (div0_q) begin
      quo = '1;
      rem = dvd_q;
    end
    res_o = '0;
    case (op_q)
      MDU_MUL:                         res_o = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: res_o = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               res_o = quo;
      default:                         res_o = rem;
    endcase
  end

  assign done_o = active_q && (cnt_q == LAST);

  // Load on start, iterate while active, abort on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      op_q     <= MDU_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      dvd_q    <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else if (flush_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      op_q     <= op_i;
      hi_q     <= '0;
      dvd_q    <= a_i;
      neg_q    <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      div0_q   <= is_div_op(op_i) && (b_i == '0);
      if (is_div_op(op_i)) begin
        lo_q  <= a_mag;
        opb_q <= b_mag;
      end else begin
        lo_q  <= b_mag;
        opb_q <= a_mag;
      end
    end else if (active_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/npc_exu_iter.sv
// Execute unit: single-cycle ALU plus iterative RV-M engine behind a
// valid/ready handshake.
// Handshake: an input is taken when in_valid & in_ready (in_ready only in
// IDLE); a result is delivered when out_valid & out_ready (out_valid only in
// DONE, result held stable meanwhile). flush overrides both handshakes.
module npc_exu_iter
  import npc_exu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      oc,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output state_e          dbg_state_o
);

  localparam int SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, mdu_start, mdu_done;
  logic [XLEN-1:0] mdu_res;
  logic            is_op, is_opimm, is_mop, alu_ok, use_sub, use_sra;
  logic [XLEN-1:0] op_b, alu_res;
  logic [SW-1:0]   shamt;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign result      = result_q;
  assign dbg_state_o = state_q;
  assign accept      = in_valid & in_ready;

  // Decode and single-cycle ALU; unsupported encodings produce 0.
  always_comb begin
    is_opimm = (oc == OPC_OP_IMM);
    is_op    = (oc == OPC_OP);
    is_mop   = MDU_EN && is_op && (funct7 == F7_MULDIV);
    alu_ok   = is_opimm || (is_op && ((funct7 == F7_BASE) || (funct7 == F7_ALT)));
    op_b     = is_opimm ? imm : data2;
    shamt    = op_b[SW-1:0];
    use_sub  = is_op && funct7[5];
    use_sra  = is_opimm ? imm[10] : funct7[5];
    alu_res  = '0;
    case (funct3)
      F3_ADD:  alu_res = use_sub ? (data1 - op_b) : (data1 + op_b);
      F3_SLL:  alu_res = data1 << shamt;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(op_b))};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (data1 < op_b)};
      F3_XOR:  alu_res = data1 ^ op_b;
      F3_SR:   alu_res = use_sra ? XLEN'($signed(data1) >>> shamt) : (data1 >> shamt);
      F3_OR:   alu_res = data1 | op_b;
      F3_AND:  alu_res = data1 & op_b;
      default: alu_res = '0;
    endcase
    if (!alu_ok) alu_res = '0;
  end

  npc_exu_mdu #(.XLEN(XLEN)) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mdu_start),
    .flush_i (flush),
    .op_i    (mdu_op_e'(funct3)),
    .a_i     (data1),
    .b_i     (data2),
    .done_o  (mdu_done),
    .res_o   (mdu_res)
  );

  // Next-state and result capture; flush wins over every handshake.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    mdu_start = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mop) begin
              state_d   = ST_CALC;
              mdu_start = 1'b1;
            end else begin
              state_d  = ST_DONE;
              result_d = alu_res;
            end
          end
        end
        ST_CALC: begin
          if (mdu_done) begin
            state_d  = ST_DONE;
            result_d = mdu_res;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_npc_exu_iter.sv
// Bench for npc_exu_iter (XLEN=32): directed vector table, random ops against
// an arithmetic reference model, and hand-written stall/flush/reset sequences.
module tb_npc_exu_iter;
  import npc_exu_pkg::*;

  localparam int W = 32;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [6:0]   oc, funct7;
  logic [2:0]   funct3;
  logic [W-1:0] data1, data2, imm;
  logic         flush, out_valid, out_ready, busy;
  logic [W-1:0] result;
  state_e       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [6:0]   oc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [W-1:0] d1, d2, im, exp;
    int           lat;
  } vec_t;
  vec_t vecs[$];

  npc_exu_iter #(.XLEN(W), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .oc(oc), .funct3(funct3), .funct7(funct7), .data1(data1), .data2(data2),
    .imm(imm), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the RISC-V definitions.
  function automatic logic [W-1:0] model(input logic [6:0] o, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [W-1:0] a,
                                         input logic [W-1:0] b2, input logic [W-1:0] im);
    logic [W-1:0] b;
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    int sh;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b2));
    ua  = {32'd0, a};
    ub  = {32'd0, b2};
    ovf = (a == 32'h8000_0000) && (b2 == 32'hffff_ffff);
    if (o == OPR && f7 == 7'b0000001) begin
      case (f3)
        3'd0: begin up = ua * ub; return up[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * longint'(ub); return p[63:32]; end
        3'd3: begin up = ua * ub; return up[63:32]; end
        3'd4: begin if (b2 == 0) return '1; if (ovf) return 32'h8000_0000; p = sa / sb; return p[31:0]; end
        3'd5: begin if (b2 == 0) return '1; return a / b2; end
        3'd6: begin if (b2 == 0) return a; if (ovf) return '0; p = sa % sb; return p[31:0]; end
        default: begin if (b2 == 0) return a; return a % b2; end
      endcase
    end
    if (o == OPI) b = im;
    else if (o == OPR && (f7 == 7'h00 || f7 == 7'h20)) b = b2;
    else return '0;
    sh = int'(b[4:0]);
    case (f3)
      3'd0: return (o == OPR && f7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if ((o == OPI) ? im[10] : f7[5]) return $signed(a) >>> sh;
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int model_lat(input logic [6:0] o, input logic [6:0] f7);
    return (o == OPR && f7 == 7'b0000001) ? W + 1 : 1;
  endfunction

  function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [W-1:0] d1, input logic [W-1:0] d2,
                              input logic [W-1:0] im, input logic [W-1:0] e, input int l);
    vec_t v;
    v.oc = o; v.f3 = f3; v.f7 = f7; v.d1 = d1; v.d2 = d2; v.im = im; v.exp = e; v.lat = l;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom();
    endcase
  endfunction

  // driver: present one op, measure cycles to out_valid, then complete the handshake
  task automatic exec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] im,
                      output logic [W-1:0] res, output int lat);
    @(negedge clk);
    oc = o; funct3 = f3; funct7 = f7; data1 = a; data2 = b; imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    data1 = $urandom(); data2 = $urandom(); imm = $urandom();
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_hs", in_ready, 1'b1);
    check("out_valid_after_hs", out_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_result"}, result, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    logic [W-1:0] got, e;
    int lat, cnt;
    logic [6:0] o, f7;
    logic [2:0] f3;
    logic [W-1:0] a, b, im;
    logic [11:0] i12;

    // reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    oc = '0; funct3 = '0; funct7 = '0; data1 = '0; data2 = '0; imm = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // directed vector table
    vecs.push_back(mk(OPI, 3'd0, 7'h7f, 32'd5, 32'd0, 32'hffff_fffd, 32'd2, 1));
    vecs.push_back(mk(OPR, 3'd0, 7'h20, 32'd0, 32'd1, 32'd0, 32'hffff_ffff, 1));
    vecs.push_back(mk(OPI, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'hf800_0000, 1));
    vecs.push_back(mk(OPR, 3'd3, 7'h01, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 32'hffff_fffe, 33));
    vecs.push_back(mk(OPR, 3'd4, 7'h01, 32'd7, 32'd0, 32'd0, 32'hffff_ffff, 33));
    vecs.push_back(mk(OPR, 3'd6, 7'h01, 32'd7, 32'd0, 32'd0, 32'd7, 33));
    vecs.push_back(mk(OPR, 3'd4, 7'h01, 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, 33));
    vecs.push_back(mk(OPR, 3'd6, 7'h01, 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'd0, 33));
    vecs.push_back(mk(OPR, 3'd0, 7'h01, 32'd3, 32'hffff_fffe, 32'd0, 32'hffff_fffa, 33));
    vecs.push_back(mk(OPR, 3'd1, 7'h01, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 32'd0, 33));
    vecs.push_back(mk(OPR, 3'd2, 7'h01, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 32'hffff_ffff, 33));
    vecs.push_back(mk(OPR, 3'd5, 7'h01, 32'd100, 32'd7, 32'd0, 32'd14, 33));
    vecs.push_back(mk(OPR, 3'd7, 7'h01, 32'd100, 32'd7, 32'd0, 32'd2, 33));
    vecs.push_back(mk(OPR, 3'd4, 7'h01, 32'hffff_fff9, 32'd2, 32'd0, 32'hffff_fffd, 33));
    vecs.push_back(mk(OPR, 3'd6, 7'h01, 32'hffff_fff9, 32'd2, 32'd0, 32'hffff_ffff, 33));
    vecs.push_back(mk(OPR, 3'd4, 7'h01, 32'hffff_ffff, 32'd0, 32'd0, 32'hffff_ffff, 33));
    vecs.push_back(mk(OPR, 3'd6, 7'h01, 32'hffff_fff8, 32'd0, 32'd0, 32'hffff_fff8, 33));
    vecs.push_back(mk(OPR, 3'd2, 7'h00, 32'hffff_ffff, 32'd1, 32'd0, 32'd1, 1));
    vecs.push_back(mk(OPR, 3'd3, 7'h00, 32'hffff_ffff, 32'd1, 32'd0, 32'd0, 1));
    vecs.push_back(mk(OPR, 3'd5, 7'h00, 32'h8000_0000, 32'h0000_0021, 32'd0, 32'h4000_0000, 1));
    vecs.push_back(mk(OPI, 3'd4, 7'h7c, 32'h0f0f_0f0f, 32'd0, 32'hffff_f800, 32'hf0f0_f70f, 1));
    vecs.push_back(mk(OPR, 3'd0, 7'h00, 32'h7fff_ffff, 32'd1, 32'd0, 32'h8000_0000, 1));
    vecs.push_back(mk(LUI, 3'd0, 7'h00, 32'd9, 32'd9, 32'd9, 32'd0, 1));
    vecs.push_back(mk(OPR, 3'd0, 7'h02, 32'd9, 32'd9, 32'd0, 32'd0, 1));
    foreach (vecs[i]) begin
      exec(vecs[i].oc, vecs[i].f3, vecs[i].f7, vecs[i].d1, vecs[i].d2, vecs[i].im, got, lat);
      check($sformatf("vec%0d_result", i), got, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: o = OPI;
        9:          o = LUI;
        default:    o = OPR;
      endcase
      f3  = 3'($urandom_range(0, 7));
      i12 = 12'($urandom());
      im  = {{20{i12[11]}}, i12};
      a   = rnd_val();
      b   = rnd_val();
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'h01;
      endcase
      if (o == OPI) f7 = im[11:5];
      exp_q.push_back(model(o, f3, f7, a, b, im));
      exec(o, f3, f7, a, b, im, got, lat);
      e = exp_q.pop_front();
      if (got !== e) $display("  op oc=%b f3=%0d f7=%b a=%h b=%h imm=%h", o, f3, f7, a, b, im);
      check($sformatf("rnd%0d_result", n), got, e);
      check($sformatf("rnd%0d_latency", n), lat, model_lat(o, f7));
    end

    // out_ready held low: result stable, in_ready low, out_valid high
    @(negedge clk);
    oc = OPR; funct3 = 3'd0; funct7 = 7'h00; data1 = 32'd1000; data2 = 32'd234; imm = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; data1 = '0; data2 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_out_valid", k), out_valid, 1'b1);
      check($sformatf("stall%0d_in_ready", k), in_ready, 1'b0);
      check($sformatf("stall%0d_result", k), result, 32'd1234);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("stall_release_in_ready", in_ready, 1'b1);

    // flush at CALC cycle 5 of a multiply
    oc = OPR; funct3 = 3'd0; funct7 = 7'h01; data1 = 32'd6; data2 = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("flush_pre_busy", busy, 1'b1);
    check("flush_pre_state", dbg_state, ST_CALC);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_state", dbg_state, ST_IDLE);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_busy", busy, 1'b0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_out_valid", cnt, 0);

    // flush dominates a simultaneous accept
    oc = OPR; funct3 = 3'd0; funct7 = 7'h00; data1 = 32'd1; data2 = 32'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_accept_out_valid", out_valid, 1'b0);
    check("flush_accept_busy", busy, 1'b0);

    // flush in DONE clears out_valid
    exec(OPI, 3'd6, 7'h00, 32'h00f0, 32'd0, 32'h000f, got, lat);
    check("or_result", got, 32'h00ff);
    oc = OPI; funct3 = 3'd0; data1 = 32'd1; imm = 32'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("done_before_flush", out_valid, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("done_flush_out_valid", out_valid, 1'b0);

    // reset pulsed mid-divide
    oc = OPR; funct3 = 3'd4; funct7 = 7'h01; data1 = 32'd1000; data2 = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_div_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_div_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_rst_no_out_valid", cnt, 0);
    exec(OPR, 3'd0, 7'h00, 32'd12, 32'd30, 32'd0, got, lat);
    check("post_rst_add_result", got, 32'd42);
    check("post_rst_add_latency", lat, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
